alu_reg_unit: RTL and testbench



---
 rtl/alu_reg_unit.sv | 157 +++++++++++++++
 tb/tb_alu_reg_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_reg_unit.sv
// ---------------------------------------------------------------------------
// alu_reg_unit
//
// Purpose:
//   Accumulator/ALU slice of the CPU datapath. It holds two independent
//   sub-units behind one module boundary:
//     - a purely combinational 8-function ALU (oc, a, b -> f)
//     - a clocked multi-function register (clear, load, inc, dec, shifts)
//   The ALU and the register are not connected inside this module. The
//   datapath around it wires them together.
//
// Parameters:
//   WIDTH  - width of the ALU operands/result and of the register (default 4)
//
// Ports:
//   clk    in   1      system clock, register updates on the rising edge
//   rst_n  in   1      asynchronous active-low reset, clears the register
//   oc     in   3      ALU opcode
//   a, b   in   WIDTH  ALU operands
//   f      out  WIDTH  ALU result (combinational)
//   z, c   out  1      ALU zero / carry-borrow flags (only with ALU_FLAGS_EN)
//   cl     in   1      register synchronous clear (highest priority)
//   ld     in   1      register parallel load of 'in'
//   in     in   WIDTH  register parallel load data
//   inc    in   1      register increment (wraps)
//   dec    in   1      register decrement (wraps)
//   sr     in   1      register shift right, 'ir' enters the MSB
//   ir     in   1      serial input for shift right
//   sl     in   1      register shift left, 'il' enters the LSB
//   il     in   1      serial input for shift left
//   out    out  WIDTH  register contents
//
// Configuration:
//   ALU_FLAGS_EN - when defined, adds the combinational z and c flag outputs.
// ---------------------------------------------------------------------------
module alu_reg_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       oc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] f,
`ifdef ALU_FLAGS_EN
    output logic             z,
    output logic             c,
`endif
    input  logic             cl,
    input  logic             ld,
    input  logic [WIDTH-1:0] in,
    input  logic             inc,
    input  logic             dec,
    input  logic             sr,
    input  logic             ir,
    input  logic             sl,
    input  logic             il,
    output logic [WIDTH-1:0] out
);

    // Opcode encodings of the ALU.
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_NOT = 3'b100,
        OP_XOR = 3'b101,
        OP_OR  = 3'b110,
        OP_AND = 3'b111
    } aluOp_e;

    logic [WIDTH-1:0] aluSum;
    logic [WIDTH-1:0] aluDiff;
    logic [WIDTH-1:0] aluProd;
    logic [WIDTH-1:0] aluQuot;
    logic [WIDTH-1:0] aluResult;

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;

    // Arithmetic terms are all computed at WIDTH bits, so the modulo-2^WIDTH
    // wrap falls out of the operator widths. Division by zero is steered to
    // all ones so the result is never X.
    always_comb begin
        aluSum  = a + b;
        aluDiff = a - b;
        aluProd = a * b;
        aluQuot = '1;
        if (b != '0) begin
            aluQuot = a / b;
        end
    end

    // Opcode select of the combinational ALU result.
    always_comb begin
        aluResult = '0;
        case (aluOp_e'(oc))
            OP_ADD:  aluResult = aluSum;
            OP_SUB:  aluResult = aluDiff;
            OP_MUL:  aluResult = aluProd;
            OP_DIV:  aluResult = aluQuot;
            OP_NOT:  aluResult = ~a;
            OP_XOR:  aluResult = a ^ b;
            OP_OR:   aluResult = a | b;
            OP_AND:  aluResult = a & b;
            default: aluResult = '0;
        endcase
    end

    assign f = aluResult;

`ifdef ALU_FLAGS_EN
    // A WIDTH-bit sum that came out smaller than an operand must have
    // wrapped, which is exactly a carry out. Subtraction borrows when a < b.
    always_comb begin
        z = (aluResult == '0);
        c = 1'b0;
        if (aluOp_e'(oc) == OP_ADD) begin
            c = (aluSum < a);
        end else if (aluOp_e'(oc) == OP_SUB) begin
            c = (a < b);
        end
    end
`endif

    // Next-state of the register: a strict priority chain, so exactly one
    // action takes effect and every lower-priority control is ignored.
    always_comb begin
        acc_d = acc_q;
        if (cl) begin
            acc_d = '0;
        end else if (ld) begin
            acc_d = in;
        end else if (inc) begin
            acc_d = acc_q + 1'b1;
        end else if (dec) begin
            acc_d = acc_q - 1'b1;
        end else if (sr) begin
            acc_d = {ir, acc_q[WIDTH-1:1]};
        end else if (sl) begin
            acc_d = {acc_q[WIDTH-2:0], il};
        end
    end

    // Register state. Reset is asynchronous and clears it immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign out = acc_q;

endmodule

// File: tb/tb_alu_reg_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_reg_unit
//
// Self-checking bench for alu_reg_unit. Expected values go onto a scoreboard
// queue when stimulus is driven and are popped when the DUT output is
// sampled. Build with +define+ALU_FLAGS_EN to also exercise the flags.
// ---------------------------------------------------------------------------
module tb_alu_reg_unit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   oc;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] f;
    logic         cl, ld, inc, dec, sr, ir, sl, il;
    logic [W-1:0] regIn;
    logic [W-1:0] regOut;
`ifdef ALU_FLAGS_EN
    logic         z;
    logic         c;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    logic [W-1:0] expQ[$];
    logic [W-1:0] model;

    alu_reg_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .oc    (oc),
        .a     (a),
        .b     (b),
        .f     (f),
`ifdef ALU_FLAGS_EN
        .z     (z),
        .c     (c),
`endif
        .cl    (cl),
        .ld    (ld),
        .in    (regIn),
        .inc   (inc),
        .dec   (dec),
        .sr    (sr),
        .ir    (ir),
        .sl    (sl),
        .il    (il),
        .out   (regOut)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Reference ALU using integer arithmetic, reduced to 4 bits at the end.
    function automatic logic [W-1:0] refAlu(input int op, input int x, input int y);
        int r;
        case (op)
            0:       r = (x + y) % 16;
            1:       r = (x - y + 16) % 16;
            2:       r = (x * y) % 16;
            3:       r = (y == 0) ? 15 : (x / y);
            4:       r = 15 - x;
            5:       r = x ^ y;
            6:       r = x | y;
            default: r = x & y;
        endcase
        return r[W-1:0];
    endfunction

    // Reference register behaviour: fixed-priority action selection.
    function automatic logic [W-1:0] refReg(input logic [W-1:0] cur,
                                            input logic pCl, input logic pLd,
                                            input logic pInc, input logic pDec,
                                            input logic pSr, input logic pIr,
                                            input logic pSl, input logic pIl,
                                            input logic [W-1:0] pIn);
        int v;
        v = int'(cur);
        if (pCl)       v = 0;
        else if (pLd)  v = int'(pIn);
        else if (pInc) v = (v + 1) % 16;
        else if (pDec) v = (v + 15) % 16;
        else if (pSr)  v = (v / 2) + (pIr ? 8 : 0);
        else if (pSl)  v = ((v * 2) % 16) + (pIl ? 1 : 0);
        return v[W-1:0];
    endfunction

    task automatic idleControls();
        cl = 0; ld = 0; inc = 0; dec = 0; sr = 0; ir = 0; sl = 0; il = 0;
        regIn = '0;
    endtask

    // Drive one ALU vector, push its expected result, sample, pop, compare.
    task automatic aluCheck(input int op, input int x, input int y,
                            input logic [W-1:0] expected, input string name);
        logic [W-1:0] e;
        expQ.push_back(expected);
        oc = op[2:0];
        a  = x[W-1:0];
        b  = y[W-1:0];
        #1;
        testsRun++;
        if (expQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL %s: scoreboard empty", name);
        end else begin
            e = expQ.pop_front();
            if (f !== e) begin
                testsFailed++;
                $display("[TB] FAIL %s: oc=%0d a=%h b=%h f=%h expected %h",
                         name, op, x[W-1:0], y[W-1:0], f, e);
            end
        end
    endtask

    // Drive controls at the falling edge, push the model result, sample just
    // after the next rising edge, pop and compare.
    task automatic regCycle(input logic pCl, input logic pLd, input logic pInc,
                            input logic pDec, input logic pSr, input logic pIr,
                            input logic pSl, input logic pIl,
                            input logic [W-1:0] pIn, input string name);
        logic [W-1:0] e;
        @(negedge clk);
        cl = pCl; ld = pLd; inc = pInc; dec = pDec;
        sr = pSr; ir = pIr; sl = pSl; il = pIl; regIn = pIn;
        e = refReg(model, pCl, pLd, pInc, pDec, pSr, pIr, pSl, pIl, pIn);
        expQ.push_back(e);
        @(posedge clk);
        #1;
        model = e;
        testsRun++;
        if (expQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL %s: scoreboard empty", name);
        end else begin
            e = expQ.pop_front();
            if (regOut !== e) begin
                testsFailed++;
                $display("[TB] FAIL %s: out=%h expected %h", name, regOut, e);
            end
        end
        idleControls();
    endtask

    task automatic test_reset();
        // Out of power-on reset the register must read zero.
        testsRun++;
        if (regOut !== 4'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_initial: out=%h expected 0", regOut);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model = '0;

        regCycle(0, 1, 0, 0, 0, 0, 0, 0, 4'h9, "reset_load9");
        // Now 1 unit after a rising edge; pulse reset well before the next one.
        #2;
        rst_n = 1'b0;
        #1;
        testsRun++;
        if (regOut !== 4'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_async: out=%h expected 0", regOut);
        end
        #2;
        rst_n = 1'b1;
        model = '0;
        regCycle(0, 0, 0, 0, 0, 0, 0, 0, 4'h0, "reset_hold_after");
        regCycle(0, 0, 1, 0, 0, 0, 0, 0, 4'h0, "reset_first_inc");
    endtask

    task automatic test_alu_spot();
        aluCheck(0, 4'h9, 4'h8, 4'h1, "alu_add_wrap");
        aluCheck(1, 4'h3, 4'h5, 4'hE, "alu_sub_wrap");
        aluCheck(2, 4'h7, 4'h3, 4'h5, "alu_mul_low");
        aluCheck(3, 4'hD, 4'h4, 4'h3, "alu_div");
        aluCheck(3, 4'h7, 4'h0, 4'hF, "alu_div_zero");
        aluCheck(3, 4'h0, 4'h0, 4'hF, "alu_div_zero_zero");
        aluCheck(4, 4'hA, 4'h2, 4'h5, "alu_not");
        aluCheck(5, 4'hC, 4'hA, 4'h6, "alu_xor");
        aluCheck(6, 4'hC, 4'h3, 4'hF, "alu_or");
        aluCheck(7, 4'hC, 4'h6, 4'h4, "alu_and");
    endtask

    task automatic test_alu_sweep();
        for (int op = 0; op < 8; op++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    aluCheck(op, x, y, refAlu(op, x, y), "alu_sweep");
                end
            end
        end
    endtask

    task automatic test_load_count();
        regCycle(0, 1, 0, 0, 0, 0, 0, 0, 4'hE, "cnt_load_E");
        regCycle(0, 0, 1, 0, 0, 0, 0, 0, 4'h0, "cnt_inc_F");
        regCycle(0, 0, 1, 0, 0, 0, 0, 0, 4'h0, "cnt_inc_wrap");
        regCycle(0, 0, 0, 1, 0, 0, 0, 0, 4'h0, "cnt_dec_wrap");
        regCycle(0, 0, 0, 0, 0, 0, 0, 0, 4'h0, "cnt_hold");
    endtask

    task automatic test_shifts();
        regCycle(0, 1, 0, 0, 0, 0, 0, 0, 4'h6, "sh_load6");
        regCycle(0, 0, 0, 0, 1, 1, 0, 0, 4'h0, "sh_sr_ir1");
        regCycle(0, 0, 0, 0, 0, 0, 1, 0, 4'h0, "sh_sl_il0");
        regCycle(0, 0, 0, 0, 0, 0, 1, 1, 4'h0, "sh_sl_il1");
        regCycle(0, 0, 0, 0, 1, 0, 1, 1, 4'h0, "sh_sr_over_sl");
    endtask

    task automatic test_priority();
        regCycle(0, 1, 0, 0, 0, 0, 0, 0, 4'h5, "pri_load5");
        regCycle(1, 1, 1, 0, 1, 1, 0, 0, 4'h3, "pri_cl_wins");
        regCycle(0, 1, 0, 0, 0, 0, 0, 0, 4'h5, "pri_reload5");
        regCycle(0, 1, 1, 1, 0, 0, 0, 0, 4'h3, "pri_ld_wins");
        regCycle(0, 0, 1, 1, 0, 0, 0, 0, 4'h0, "pri_inc_over_dec");
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++) begin
            regCycle(($urandom_range(7) == 0), ($urandom_range(3) == 0),
                     1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), 1'($urandom), 4'($urandom), "random");
        end
    endtask

`ifdef ALU_FLAGS_EN
    task automatic test_flags();
        aluCheck(0, 4'h7, 4'h9, 4'h0, "flag_add_f");
        testsRun++;
        if (z !== 1'b1 || c !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL flag_add_7_9: z=%b c=%b expected z=1 c=1", z, c);
        end
        aluCheck(0, 4'h3, 4'h4, 4'h7, "flag_add_nc_f");
        testsRun++;
        if (z !== 1'b0 || c !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL flag_add_3_4: z=%b c=%b expected z=0 c=0", z, c);
        end
        aluCheck(1, 4'h3, 4'h5, 4'hE, "flag_sub_f");
        testsRun++;
        if (c !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL flag_sub_borrow: c=%b expected 1", c);
        end
        aluCheck(7, 4'hC, 4'h3, 4'h0, "flag_and_f");
        testsRun++;
        if (z !== 1'b1 || c !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL flag_and_zero: z=%b c=%b expected z=1 c=0", z, c);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        oc = '0; a = '0; b = '0;
        idleControls();
        model = '0;
        #2;
        test_reset();
        test_alu_spot();
        test_alu_sweep();
`ifdef ALU_FLAGS_EN
        test_flags();
`endif
        test_load_count();
        test_shifts();
        test_priority();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
